// File: rtl/minisys_id_stage_if.sv
// IF/ID-side inputs, WB write-back port and the ID/EX register outputs of the MiniSys-1A decode stage.
// The slave modport is the decode stage itself; the master modport is whatever surrounds it.
interface minisys_id_stage_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
);
  logic [31:0]        instrD;
  logic [DATA_W-1:0]  pcplus4D;
  logic               regwriteW;
  logic [RADDR_W-1:0] writeregW;
  logic [DATA_W-1:0]  resultW;
  logic               flushE;

  logic               stallD;
  logic [DATA_W-1:0]  rd1E;
  logic [DATA_W-1:0]  rd2E;
  logic [DATA_W-1:0]  immE;
  logic [RADDR_W-1:0] rsE;
  logic [RADDR_W-1:0] rtE;
  logic [RADDR_W-1:0] rdE;
  logic [4:0]         shamtE;
  logic [DATA_W-1:0]  pcplus4E;
  logic               regwriteE;
  logic               memtoregE;
  logic               memwriteE;
  logic               branchE;
  logic               alusrcE;
  logic               regdstE;
  logic [3:0]         alucontrolE;
  logic               illegalE;

  modport master (
    output instrD, pcplus4D, regwriteW, writeregW, resultW, flushE,
    input  stallD, rd1E, rd2E, immE, rsE, rtE, rdE, shamtE, pcplus4E,
    input  regwriteE, memtoregE, memwriteE, branchE, alusrcE, regdstE,
    input  alucontrolE, illegalE
  );

  modport slave (
    input  instrD, pcplus4D, regwriteW, writeregW, resultW, flushE,
    output stallD, rd1E, rd2E, immE, rsE, rtE, rdE, shamtE, pcplus4E,
    output regwriteE, memtoregE, memwriteE, branchE, alusrcE, regdstE,
    output alucontrolE, illegalE
  );
endinterface

// File: rtl/minisys_id_stage.sv
// MiniSys-1A decode stage: register file with WB write-through, opcode/funct decode,
// immediate extension, load-use stall detection and the ID/EX pipeline register.
module minisys_id_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input logic               clk,
  input logic               clrn,
  minisys_id_stage_if.slave bus
);

  localparam int NREGS = 1 << RADDR_W;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_NOR  = 4'h5;
  localparam logic [3:0] ALU_SLT  = 4'h6;
  localparam logic [3:0] ALU_SLTU = 4'h7;
  localparam logic [3:0] ALU_SLL  = 4'h8;
  localparam logic [3:0] ALU_SRL  = 4'h9;
  localparam logic [3:0] ALU_SRA  = 4'hA;
  localparam logic [3:0] ALU_LUI  = 4'hB;

  logic [DATA_W-1:0]  r_regs [NREGS];

  logic [5:0]         w_op;
  logic [5:0]         w_funct;
  logic [RADDR_W-1:0] w_rs;
  logic [RADDR_W-1:0] w_rt;
  logic [RADDR_W-1:0] w_rd;
  logic [DATA_W-1:0]  w_rd1;
  logic [DATA_W-1:0]  w_rd2;
  logic [DATA_W-1:0]  w_imm;
  logic               w_signExt;
  logic               w_regwrite;
  logic               w_memtoreg;
  logic               w_memwrite;
  logic               w_branch;
  logic               w_alusrc;
  logic               w_regdst;
  logic [3:0]         w_alucontrol;
  logic               w_illegal;
  logic               w_stall;
  logic               w_bubble;

  logic [DATA_W-1:0]  r_rd1;
  logic [DATA_W-1:0]  r_rd2;
  logic [DATA_W-1:0]  r_imm;
  logic [RADDR_W-1:0] r_rs;
  logic [RADDR_W-1:0] r_rt;
  logic [RADDR_W-1:0] r_rd;
  logic [4:0]         r_shamt;
  logic [DATA_W-1:0]  r_pcplus4;
  logic               r_regwrite;
  logic               r_memtoreg;
  logic               r_memwrite;
  logic               r_branch;
  logic               r_alusrc;
  logic               r_regdst;
  logic [3:0]         r_alucontrol;
  logic               r_illegal;

  assign w_op    = bus.instrD[31:26];
  assign w_funct = bus.instrD[5:0];
  assign w_rs    = bus.instrD[25:21];
  assign w_rt    = bus.instrD[20:16];
  assign w_rd    = bus.instrD[15:11];

  // $0 is never written, so a write-back aimed at it must not leak through the bypass either.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (bus.regwriteW && (bus.writeregW != '0)) begin
      r_regs[bus.writeregW] <= bus.resultW;
    end
  end

  always_comb begin
    w_rd1 = r_regs[w_rs];
    w_rd2 = r_regs[w_rt];
    if (bus.regwriteW && (bus.writeregW == w_rs)) w_rd1 = bus.resultW;
    if (bus.regwriteW && (bus.writeregW == w_rt)) w_rd2 = bus.resultW;
    if (w_rs == '0) w_rd1 = '0;
    if (w_rt == '0) w_rd2 = '0;
  end

  always_comb begin
    w_regwrite   = 1'b0;
    w_memtoreg   = 1'b0;
    w_memwrite   = 1'b0;
    w_branch     = 1'b0;
    w_alusrc     = 1'b0;
    w_regdst     = 1'b0;
    w_alucontrol = ALU_ADD;
    w_illegal    = 1'b0;
    w_signExt    = 1'b1;
    // The all-zero word is the canonical nop; it is kept free of any control side effect.
    if (bus.instrD != 32'h0) begin
      case (w_op)
        6'h00: begin
          w_regwrite = 1'b1;
          w_regdst   = 1'b1;
          case (w_funct)
            6'h20, 6'h21: w_alucontrol = ALU_ADD;
            6'h22, 6'h23: w_alucontrol = ALU_SUB;
            6'h24:        w_alucontrol = ALU_AND;
            6'h25:        w_alucontrol = ALU_OR;
            6'h26:        w_alucontrol = ALU_XOR;
            6'h27:        w_alucontrol = ALU_NOR;
            6'h2A:        w_alucontrol = ALU_SLT;
            6'h2B:        w_alucontrol = ALU_SLTU;
            6'h00:        w_alucontrol = ALU_SLL;
            6'h02:        w_alucontrol = ALU_SRL;
            6'h03:        w_alucontrol = ALU_SRA;
            default: begin
              w_regwrite = 1'b0;
              w_regdst   = 1'b0;
              w_illegal  = 1'b1;
            end
          endcase
        end
        6'h08, 6'h09: begin w_regwrite = 1'b1; w_alusrc = 1'b1; w_alucontrol = ALU_ADD;  end
        6'h0A:        begin w_regwrite = 1'b1; w_alusrc = 1'b1; w_alucontrol = ALU_SLT;  end
        6'h0B:        begin w_regwrite = 1'b1; w_alusrc = 1'b1; w_alucontrol = ALU_SLTU; end
        6'h0C: begin w_regwrite = 1'b1; w_alusrc = 1'b1; w_alucontrol = ALU_AND; w_signExt = 1'b0; end
        6'h0D: begin w_regwrite = 1'b1; w_alusrc = 1'b1; w_alucontrol = ALU_OR;  w_signExt = 1'b0; end
        6'h0E: begin w_regwrite = 1'b1; w_alusrc = 1'b1; w_alucontrol = ALU_XOR; w_signExt = 1'b0; end
        6'h0F: begin w_regwrite = 1'b1; w_alusrc = 1'b1; w_alucontrol = ALU_LUI; w_signExt = 1'b0; end
        6'h23: begin w_regwrite = 1'b1; w_memtoreg = 1'b1; w_alusrc = 1'b1; end
        6'h2B: begin w_memwrite = 1'b1; w_alusrc = 1'b1; end
        6'h04: begin w_branch = 1'b1; w_alucontrol = ALU_SUB; end
        default: w_illegal = 1'b1;
      endcase
    end
  end

  assign w_imm = w_signExt ? {{(DATA_W-16){bus.instrD[15]}}, bus.instrD[15:0]}
                           : {{(DATA_W-16){1'b0}}, bus.instrD[15:0]};

  assign w_stall  = r_memtoreg && (r_rt != '0) && ((r_rt == w_rs) || (r_rt == w_rt));
  assign w_bubble = w_stall || bus.flushE;

  // Data fields always advance; only the controls are squashed when a bubble is inserted.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_shamt      <= '0;
      r_pcplus4    <= '0;
      r_regwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_memwrite   <= 1'b0;
      r_branch     <= 1'b0;
      r_alusrc     <= 1'b0;
      r_regdst     <= 1'b0;
      r_alucontrol <= '0;
      r_illegal    <= 1'b0;
    end else begin
      r_rd1        <= w_rd1;
      r_rd2        <= w_rd2;
      r_imm        <= w_imm;
      r_rs         <= w_rs;
      r_rt         <= w_rt;
      r_rd         <= w_rd;
      r_shamt      <= bus.instrD[10:6];
      r_pcplus4    <= bus.pcplus4D;
      r_regwrite   <= w_bubble ? 1'b0 : w_regwrite;
      r_memtoreg   <= w_bubble ? 1'b0 : w_memtoreg;
      r_memwrite   <= w_bubble ? 1'b0 : w_memwrite;
      r_branch     <= w_bubble ? 1'b0 : w_branch;
      r_alusrc     <= w_bubble ? 1'b0 : w_alusrc;
      r_regdst     <= w_bubble ? 1'b0 : w_regdst;
      r_alucontrol <= w_bubble ? 4'h0 : w_alucontrol;
      r_illegal    <= w_bubble ? 1'b0 : w_illegal;
    end
  end

  assign bus.stallD      = w_stall;
  assign bus.rd1E        = r_rd1;
  assign bus.rd2E        = r_rd2;
  assign bus.immE        = r_imm;
  assign bus.rsE         = r_rs;
  assign bus.rtE         = r_rt;
  assign bus.rdE         = r_rd;
  assign bus.shamtE      = r_shamt;
  assign bus.pcplus4E    = r_pcplus4;
  assign bus.regwriteE   = r_regwrite;
  assign bus.memtoregE   = r_memtoreg;
  assign bus.memwriteE   = r_memwrite;
  assign bus.branchE     = r_branch;
  assign bus.alusrcE     = r_alusrc;
  assign bus.regdstE     = r_regdst;
  assign bus.alucontrolE = r_alucontrol;
  assign bus.illegalE    = r_illegal;

endmodule

// File: tb/tb_minisys_id_stage.sv
// Directed bench for minisys_id_stage: a decode vector table plus hand-written
// sequences for write-through, $0, load-use stall, flush and mid-stall reset.
module tb_minisys_id_stage;

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  ctrl;
    logic [3:0]  alu;
    logic        ill;
    logic [31:0] imm;
  } vec_t;

  logic clk;
  logic clrn;
  int   numApplied;
  int   numMiscompares;
  vec_t vecs [15];

  minisys_id_stage_if bus ();

  minisys_id_stage dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Controls packed as {regwrite, memtoreg, memwrite, branch, alusrc, regdst}.
  function automatic logic [5:0] ctrlE();
    return {bus.regwriteE, bus.memtoregE, bus.memwriteE, bus.branchE, bus.alusrcE, bus.regdstE};
  endfunction

  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input logic rw, input logic [4:0] wr,
                               input logic [31:0] res, input logic fl);
    @(negedge clk);
    bus.instrD    = instr;
    bus.pcplus4D  = pc;
    bus.regwriteW = rw;
    bus.writeregW = wr;
    bus.resultW   = res;
    bus.flushE    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numApplied++;
    if (act !== exp) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] ins;
    numApplied     = 0;
    numMiscompares = 0;

    vecs[0]  = '{32'h2001FFFF, 6'b100010, 4'h0, 1'b0, 32'hFFFFFFFF}; // addi $1,$0,-1
    vecs[1]  = '{32'h3402FFFF, 6'b100010, 4'h3, 1'b0, 32'h0000FFFF}; // ori $2,$0,0xFFFF
    vecs[2]  = '{32'h3C031234, 6'b100010, 4'hB, 1'b0, 32'h00001234}; // lui $3,0x1234
    vecs[3]  = '{32'h00A62022, 6'b100001, 4'h1, 1'b0, 32'h00002022}; // sub $4,$5,$6
    vecs[4]  = '{32'h000838C3, 6'b100001, 4'hA, 1'b0, 32'h000038C3}; // sra $7,$8,3
    vecs[5]  = '{32'h8D2A0004, 6'b110010, 4'h0, 1'b0, 32'h00000004}; // lw $10,4($9)
    vecs[6]  = '{32'hAD8BFFF8, 6'b001010, 4'h0, 1'b0, 32'hFFFFFFF8}; // sw $11,-8($12)
    vecs[7]  = '{32'h1022FFFF, 6'b000100, 4'h1, 1'b0, 32'hFFFFFFFF}; // beq $1,$2,-1
    vecs[8]  = '{32'h31CD8000, 6'b100010, 4'h2, 1'b0, 32'h00008000}; // andi $13,$14,0x8000
    vecs[9]  = '{32'h2C418000, 6'b100010, 4'h7, 1'b0, 32'hFFFF8000}; // sltiu $1,$2,0x8000
    vecs[10] = '{32'hFC000000, 6'b000000, 4'h0, 1'b1, 32'h00000000}; // op 0x3F
    vecs[11] = '{32'h0000003F, 6'b000000, 4'h0, 1'b1, 32'h0000003F}; // funct 0x3F
    vecs[12] = '{32'h00000000, 6'b000000, 4'h0, 1'b0, 32'h00000000}; // nop
    vecs[13] = '{32'h00430827, 6'b100001, 4'h5, 1'b0, 32'h00000827}; // nor $1,$2,$3
    vecs[14] = '{32'h00A6202A, 6'b100001, 4'h6, 1'b0, 32'h0000202A}; // slt $4,$5,$6

    clrn          = 1'b0;
    bus.instrD    = 32'h0;
    bus.pcplus4D  = 32'h0;
    bus.regwriteW = 1'b0;
    bus.writeregW = 5'd0;
    bus.resultW   = 32'h0;
    bus.flushE    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset ctrl", {26'd0, ctrlE()}, 32'h0);
    checkOutput("reset pcplus4E", bus.pcplus4E, 32'h0);
    checkOutput("reset stallD", {31'd0, bus.stallD}, 32'h0);
    @(negedge clk);
    clrn = 1'b1;

    // add $9,$8,$8 while WB writes $8
    applyStimulus(32'h01084820, 32'h100, 1'b1, 5'd8, 32'h1234, 1'b0);
    tick();
    checkOutput("bypass rd1E", bus.rd1E, 32'h1234);
    checkOutput("bypass rd2E", bus.rd2E, 32'h1234);
    checkOutput("bypass rdE", {27'd0, bus.rdE}, 32'd9);
    applyStimulus(32'h01084820, 32'h104, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    checkOutput("stored rd1E", bus.rd1E, 32'h1234);

    // $0 write attempt, then read $0
    applyStimulus(32'h00004820, 32'h108, 1'b1, 5'd0, 32'hFFFF, 1'b0);
    tick();
    checkOutput("zero bypass rd1E", bus.rd1E, 32'h0);
    applyStimulus(32'h00004820, 32'h10C, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    checkOutput("zero read rd1E", bus.rd1E, 32'h0);
    checkOutput("zero read rd2E", bus.rd2E, 32'h0);

    for (int i = 0; i < 15; i++) begin
      ins = vecs[i].instr;
      applyStimulus(ins, 32'h400 + 32'(i) * 4, 1'b0, 5'd0, 32'h0, 1'b0);
      tick();
      checkOutput($sformatf("v%0d ctrl", i), {26'd0, ctrlE()}, {26'd0, vecs[i].ctrl});
      checkOutput($sformatf("v%0d alu", i), {28'd0, bus.alucontrolE}, {28'd0, vecs[i].alu});
      checkOutput($sformatf("v%0d illegal", i), {31'd0, bus.illegalE}, {31'd0, vecs[i].ill});
      checkOutput($sformatf("v%0d imm", i), bus.immE, vecs[i].imm);
      checkOutput($sformatf("v%0d fields", i), {12'd0, bus.rsE, bus.rtE, bus.rdE, bus.shamtE},
                  {12'd0, ins[25:21], ins[20:16], ins[15:11], ins[10:6]});
      checkOutput($sformatf("v%0d pcplus4E", i), bus.pcplus4E, 32'h400 + 32'(i) * 4);
    end

    // lw $2,0($1) ; add $3,$2,$4
    applyStimulus(32'h8C220000, 32'h200, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    checkOutput("lu lw memtoregE", {31'd0, bus.memtoregE}, 32'd1);
    applyStimulus(32'h00441820, 32'h204, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    checkOutput("lu stallD", {31'd0, bus.stallD}, 32'd1);
    tick();
    checkOutput("lu bubble ctrl", {26'd0, ctrlE()}, 32'h0);
    checkOutput("lu bubble rsE", {27'd0, bus.rsE}, 32'd2);
    checkOutput("lu stall released", {31'd0, bus.stallD}, 32'd0);
    tick();
    checkOutput("lu issue ctrl", {26'd0, ctrlE()}, 32'b100001);
    checkOutput("lu issue rsE", {27'd0, bus.rsE}, 32'd2);

    // stall and flush together
    applyStimulus(32'h8C220000, 32'h208, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    applyStimulus(32'h00441820, 32'h20C, 1'b0, 5'd0, 32'h0, 1'b1);
    #1;
    checkOutput("sf stallD", {31'd0, bus.stallD}, 32'd1);
    tick();
    checkOutput("sf bubble ctrl", {26'd0, ctrlE()}, 32'h0);
    applyStimulus(32'h00441820, 32'h20C, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    checkOutput("sf issue ctrl", {26'd0, ctrlE()}, 32'b100001);

    // lw $0 never stalls even when ID reads $0
    applyStimulus(32'h8C200000, 32'h210, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    applyStimulus(32'h00041820, 32'h214, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    checkOutput("rt0 stallD", {31'd0, bus.stallD}, 32'd0);
    tick();
    checkOutput("rt0 ctrl", {26'd0, ctrlE()}, 32'b100001);

    // flush a valid sw
    applyStimulus(32'hAD8BFFF8, 32'h218, 1'b0, 5'd0, 32'h0, 1'b1);
    tick();
    checkOutput("flush memwriteE", {31'd0, bus.memwriteE}, 32'd0);
    checkOutput("flush immE", bus.immE, 32'hFFFFFFF8);
    applyStimulus(32'hAD8BFFF8, 32'h21C, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    checkOutput("noflush memwriteE", {31'd0, bus.memwriteE}, 32'd1);

    // reset in the middle of a load-use stall
    applyStimulus(32'h00000000, 32'h300, 1'b1, 5'd5, 32'hABCD, 1'b0);
    tick();
    applyStimulus(32'h00A50820, 32'h304, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    checkOutput("r5 before reset", bus.rd1E, 32'hABCD);
    applyStimulus(32'h8C250000, 32'h308, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    applyStimulus(32'h00A50820, 32'h30C, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    checkOutput("rst pre stallD", {31'd0, bus.stallD}, 32'd1);
    #1;
    clrn = 1'b0;
    #1;
    checkOutput("rst stallD", {31'd0, bus.stallD}, 32'd0);
    checkOutput("rst ctrl", {26'd0, ctrlE()}, 32'h0);
    checkOutput("rst rtE", {27'd0, bus.rtE}, 32'd0);
    checkOutput("rst rd1E", bus.rd1E, 32'h0);
    checkOutput("rst pcplus4E", bus.pcplus4E, 32'h0);
    @(negedge clk);
    clrn = 1'b1;
    tick();
    checkOutput("r5 after reset", bus.rd1E, 32'h0);
    checkOutput("after reset ctrl", {26'd0, ctrlE()}, 32'b100001);

    $display("== %0d vectors applied, %0d miscompares ==", numApplied, numMiscompares);
    $finish;
  end

endmodule
